// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: FIFO read side, flush request and packed output stream
interface fifo_rd_packer_if #(
   parameter int DWIDTH = 8,
   parameter int LANES  = 4
);
   logic                     empty;
   logic                     pop;
   logic [DWIDTH-1:0]        rdata;
   logic                     flush;
   logic [DWIDTH*LANES-1:0]  out_data;
   logic [LANES-1:0]         out_keep;
   logic                     out_valid;
   logic                     out_ready;
   modport master (input empty, rdata, flush, out_ready, output pop, out_data, out_keep, out_valid);
   modport slave  (output empty, rdata, flush, out_ready, input pop, out_data, out_keep, out_valid);
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: packs LANES FIFO read entries into one word, with flush and idle timeout
module fifo_rd_packer #(
   parameter int DWIDTH  = 8,
   parameter int LANES   = 4,
   parameter int TIMEOUT = 16
) (
   input logic rclk,
   input logic reset,
   fifo_rd_packer_if.master bus
);
   localparam int CW = $clog2(LANES + 1);
   localparam int IW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic {FILL, HOLD} state_t;
   state_t                   state;
   logic                     run, inflight, flush_pending, valid;
   logic [CW-1:0]            count;
   logic [IW-1:0]            idle;
   logic [DWIDTH*LANES-1:0]  data;
   logic [LANES-1:0]         keep;
   logic [CW:0]              level;
   logic                     idle_cyc, timeout_hit, flush_req, full;
   always_comb begin
      level       = {1'b0, count} + {{CW{1'b0}}, inflight};
      full        = inflight && level == (CW+1)'(LANES);
      idle_cyc    = count != '0 && !inflight && bus.empty;
      timeout_hit = TIMEOUT > 0 && idle_cyc && idle == IW'(TIMEOUT - 1);
      flush_req   = (bus.flush || timeout_hit) && (count != '0 || inflight);
   end
   // run holds pop off until the first edge after reset release
   assign bus.pop       = run && state == FILL && !bus.empty && !flush_pending && level < (CW+1)'(LANES);
   assign bus.out_data  = data;
   assign bus.out_keep  = keep;
   assign bus.out_valid = valid;
   always_ff @(posedge rclk or posedge reset) begin
      if (reset) begin
         state         <= FILL;
         run           <= 1'b0;
         inflight      <= 1'b0;
         flush_pending <= 1'b0;
         valid         <= 1'b0;
         count         <= '0;
         idle          <= '0;
         data          <= '0;
         keep          <= '0;
      end else begin
         run      <= 1'b1;
         inflight <= bus.pop;
         if (state == FILL) begin
            if (inflight) begin
               for (int i = 0; i < LANES; i++)
                  if (count == CW'(i)) data[i*DWIDTH +: DWIDTH] <= bus.rdata;
               count <= count + 1'b1;
            end
            idle <= (idle_cyc && !timeout_hit) ? idle + 1'b1 : '0;
            // a completing capture wins over any flush in the same cycle
            if (full) begin
               state         <= HOLD;
               valid         <= 1'b1;
               keep          <= '1;
               flush_pending <= 1'b0;
               idle          <= '0;
            end else if (flush_pending && !inflight) begin
               state         <= HOLD;
               valid         <= 1'b1;
               for (int i = 0; i < LANES; i++) keep[i] <= CW'(i) < count;
               flush_pending <= 1'b0;
               idle          <= '0;
            end else if (flush_req) begin
               flush_pending <= 1'b1;
            end
         end else if (bus.out_ready) begin
            state <= FILL;
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
            count <= '0;
         end
      end
   end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed checks of packing, backpressure, flush, timeout and reset
module tb_fifo_rd_packer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   fifo_rd_packer_if #(.DWIDTH(8), .LANES(4)) bi ();
   fifo_rd_packer_if #(.DWIDTH(8), .LANES(4)) bz ();
   fifo_rd_packer #(.DWIDTH(8), .LANES(4), .TIMEOUT(16)) dut (.rclk(clk), .reset(reset), .bus(bi));
   fifo_rd_packer #(.DWIDTH(8), .LANES(4), .TIMEOUT(0))  dut_nt (.rclk(clk), .reset(reset), .bus(bz));
   logic [7:0] mem [0:15];
   int wp = 0, rp, rpz;
   int tests = 0, fails = 0;
   int pops = 0, viol = 0, zbeats = 0;
   logic [31:0] bdata [$];
   logic [3:0]  bkeep [$];
   assign bi.empty = rp == wp;
   assign bz.empty = rpz == wp;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rp <= 0;
         rpz <= 0;
         bi.rdata <= '0;
         bz.rdata <= '0;
      end else begin
         if (bi.pop) begin
            bi.rdata <= mem[rp];
            rp <= rp + 1;
         end
         if (bz.pop) begin
            bz.rdata <= mem[rpz];
            rpz <= rpz + 1;
         end
      end
   end
   always @(posedge clk) begin
      if (!reset) begin
         if (bi.pop) pops <= pops + 1;
         if (bi.pop && bi.empty) viol <= viol + 1;
         if (bi.out_valid && bi.out_ready) begin
            bdata.push_back(bi.out_data);
            bkeep.push_back(bi.out_keep);
         end
         if (bz.out_valid && bz.out_ready) zbeats <= zbeats + 1;
      end
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push(input logic [7:0] d);
      mem[wp] = d;
      wp++;
   endtask
   task automatic set_io(input logic rdy);
      bi.out_ready = rdy;
      bz.out_ready = rdy;
      bi.flush = 1'b0;
      bz.flush = 1'b0;
   endtask
   task automatic pulse_flush();
      bi.flush = 1'b1;
      bz.flush = 1'b1;
      @(negedge clk);
      bi.flush = 1'b0;
      bz.flush = 1'b0;
   endtask
   task automatic start(input logic rdy);
      @(negedge clk);
      reset = 1'b1;
      set_io(rdy);
      wp = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic wait_beats(input int n, input int lim);
      for (int i = 0; i < lim && bdata.size() < n; i++) @(negedge clk);
   endtask
   initial begin
      int n0, p0, z0;
      set_io(1'b1);
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      #1;
      chk("rst_pop", bi.pop, 0);
      chk("rst_valid", bi.out_valid, 0);
      chk("rst_data", bi.out_data, 0);
      chk("rst_keep", bi.out_keep, 0);
      @(negedge clk);
      reset = 1'b0;
      wait_beats(1, 40);
      repeat (5) @(negedge clk);
      chk("full_beats", bdata.size(), 1);
      chk("full_data", bdata[0], 32'h44332211);
      chk("full_keep", bkeep[0], 4'hF);
      chk("full_pops", pops, 4);
      start(1'b0);
      n0 = bdata.size();
      for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
      for (int i = 0; i < 40 && !bi.out_valid; i++) @(negedge clk);
      chk("bp_valid", bi.out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", bi.out_valid, 1);
         chk("bp_hold_data", bi.out_data, 32'h44332211);
         chk("bp_hold_pop", bi.pop, 0);
      end
      bi.out_ready = 1'b1;
      bz.out_ready = 1'b1;
      wait_beats(n0 + 2, 40);
      chk("bp_beats", bdata.size(), n0 + 2);
      chk("bp_data0", bdata[n0], 32'h44332211);
      chk("bp_data1", bdata[n0 + 1], 32'h88776655);
      chk("bp_keep1", bkeep[n0 + 1], 4'hF);
      start(1'b1);
      n0 = bdata.size();
      push(8'hAA); push(8'hBB);
      repeat (6) @(negedge clk);
      pulse_flush();
      wait_beats(n0 + 1, 20);
      chk("flush_beats", bdata.size(), n0 + 1);
      chk("flush_data", bdata[n0], 32'h0000BBAA);
      chk("flush_keep", bkeep[n0], 4'h3);
      start(1'b1);
      n0 = bdata.size();
      z0 = zbeats;
      push(8'h01); push(8'h02); push(8'h03);
      repeat (12) @(negedge clk);
      chk("to_early", bdata.size(), n0);
      wait_beats(n0 + 1, 40);
      chk("to_beats", bdata.size(), n0 + 1);
      chk("to_data", bdata[n0], 32'h00030201);
      chk("to_keep", bkeep[n0], 4'h7);
      repeat (40) @(negedge clk);
      chk("nt_no_beat", zbeats, z0);
      chk("nt_valid", bz.out_valid, 0);
      start(1'b1);
      push(8'h11); push(8'h22);
      repeat (6) @(negedge clk);
      chk("rmid_data_pre", bi.out_data, 32'h00002211);
      #2 reset = 1'b1;
      #1;
      chk("rmid_pop", bi.pop, 0);
      chk("rmid_valid", bi.out_valid, 0);
      chk("rmid_data", bi.out_data, 0);
      chk("rmid_keep", bi.out_keep, 0);
      wp = 0;
      n0 = bdata.size();
      push(8'h55); push(8'h66); push(8'h77); push(8'h88);
      @(negedge clk);
      reset = 1'b0;
      wait_beats(n0 + 1, 40);
      chk("rmid_beats", bdata.size(), n0 + 1);
      chk("rmid_new", bdata[n0], 32'h88776655);
      chk("rmid_new_keep", bkeep[n0], 4'hF);
      start(1'b1);
      n0 = bdata.size();
      p0 = pops;
      pulse_flush();
      repeat (20) @(negedge clk);
      chk("idle_flush_beats", bdata.size(), n0);
      chk("idle_flush_pops", pops, p0);
      chk("idle_flush_valid", bi.out_valid, 0);
      start(1'b1);
      n0 = bdata.size();
      p0 = pops;
      push(8'h0A); push(8'h0B); push(8'h0C); push(8'h0D);
      for (int i = 0; i < 40 && pops < p0 + 4; i++) @(negedge clk);
      bi.flush = 1'b1;
      bz.flush = 1'b1;
      @(negedge clk);
      bi.flush = 1'b0;
      bz.flush = 1'b0;
      repeat (30) @(negedge clk);
      chk("race_beats", bdata.size(), n0 + 1);
      chk("race_data", bdata[n0], 32'h0D0C0B0A);
      chk("race_keep", bkeep[n0], 4'hF);
      chk("no_pop_empty", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DWIDTH, 8, width of one FIFO read entry in bits.
REQ-002 Parameter LANES, 4, FIFO entries packed per output word.
REQ-003 Parameter TIMEOUT, 16, idle cycles before a partial word auto-flushes; 0 disables the timeout.
REQ-004 Port rclk  input  1  single clock; all logic on rising edge; same clock as the FIFO read side.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port empty  input  1  FIFO read-side empty flag.
REQ-007 Port pop  output  1  FIFO read request.
REQ-008 Port rdata  input  DWIDTH  FIFO read data, valid the cycle after a pop.
REQ-009 Port flush  input  1  request early emission of a partial word.
REQ-010 Port out_data  output  DWIDTH*LANES  packed word.
REQ-011 Port out_keep  output  LANES  per-lane valid mask.
REQ-012 Port out_valid  output  1  word available.
REQ-013 Port out_ready  input  1  downstream accepts the word.

Function
REQ-014 The block SHALL implement two states: FILL (collect entries) and HOLD (present word).
REQ-015 The block SHALL keep count (0..LANES) of captured entries and a 1-bit inflight register equal to the previous cycle's pop.
REQ-016 In FILL, pop SHALL equal !empty && !flush_pending && (count + inflight) < LANES; in HOLD, pop SHALL be 0.
REQ-017 When inflight=1, rdata SHALL be captured into lane count (first entry to bits [DWIDTH-1:0]), and count SHALL increment; rdata SHALL be ignored when inflight=0.
REQ-018 When a capture brings count to LANES, the next state SHALL be HOLD with out_valid=1 and out_keep all ones.
REQ-019 In HOLD, out_valid, out_data and out_keep SHALL remain stable until a cycle with out_ready=1.
REQ-020 On a HOLD handshake (out_valid && out_ready), the block SHALL clear count, out_data, out_keep and out_valid, and return to FILL. Pop resumes the following cycle.
REQ-021 A flush sampled high in FILL with count>0 or inflight=1 SHALL set flush_pending.
REQ-022 Flush sampled with count=0 and inflight=0, or in HOLD, SHALL be ignored.
REQ-023 While flush_pending and inflight=0, the block SHALL enter HOLD with out_keep = (1<<count)-1, and SHALL clear flush_pending.
REQ-024 Unused lanes of out_data SHALL be 0.
REQ-025 An idle counter SHALL count consecutive FILL cycles with count>0, inflight=0 and empty=1. Any other FILL cycle SHALL clear it.
REQ-026 When the idle counter reaches TIMEOUT (TIMEOUT>0), the block SHALL act as if flush were sampled, and the counter SHALL clear.
REQ-027 Idle counter width SHALL hold TIMEOUT without wrap; count width SHALL hold LANES.
REQ-028 The block SHALL never pop when empty=1, and SHALL never capture more than LANES entries per word.
REQ-029 Simultaneous flush and a capture that completes the word SHALL emit a full word (out_keep all ones) and discard the flush.

Reset
REQ-030 While reset=1, pop, out_valid, out_data, out_keep, count, inflight, flush_pending and the idle counter SHALL be 0, and the state SHALL be FILL, independent of rclk.
REQ-031 On reset mid-word, partially packed entries and any in-flight entry SHALL be discarded.
REQ-032 The first pop after reset deassertion SHALL occur no earlier than the first rising edge with reset=0.

Verification
REQ-033 FIFO holds 0x11,0x22,0x33,0x44; out_ready=1 -> one beat, out_data=0x44332211, out_keep=4'hF, exactly 4 pops.
REQ-034 FIFO holds 8 bytes 0x11..0x88; out_ready=0 for 10 cycles -> out_valid held, out_data=0x44332211 stable, pop=0 throughout; after ready, second beat 0x88776655.
REQ-035 Bytes 0xAA,0xBB then empty, flush pulse -> out_data=0x0000BBAA, out_keep=4'h3.
REQ-036 Bytes 0x01,0x02,0x03 then empty, TIMEOUT=16 -> beat 0x00030201 with out_keep=4'h7 after 16 idle cycles; with TIMEOUT=0, no beat.
REQ-037 Reset asserted after 2 captures -> all outputs 0 immediately; after release, next 4 bytes 0x55,0x66,0x77,0x88 -> out_data=0x88776655, out_keep=4'hF.
REQ-038 Flush with count=0, inflight=0 and FIFO empty -> no beat, pop stays 0.
